// File: rtl/nibble_tx.sv
// -----------------------------------------------------------------------------
// nibble_tx
// Serialises WORD_W-bit words, accepted on a valid/ready handshake, into a
// stream of 4-bit beats on a valid/ready output. The nibble order is set by
// MSB_FIRST. Throughput is one nibble per cycle. A new word can load on the
// same edge that the previous word's last nibble leaves, so consecutive
// words have no gap between them.
//
// Parameters
//   WORD_W     input word width; must be a multiple of 4 and at least 4
//   MSB_FIRST  1: send [WORD_W-1 -: 4] first, 0: send [3:0] first
//
// Ports
//   i_clk         clock, all state on the rising edge
//   i_rst_n       asynchronous active-low reset
//   i_word        word to transmit, sampled only on word accept
//   i_word_valid  i_word is valid
//   o_word_ready  block accepts i_word this cycle
//   o_data        current nibble
//   o_data_valid  o_data is valid
//   i_data_ready  downstream consumes o_data this cycle
//   o_last        current nibble is the final nibble of its word
//   o_busy        a word is held (SEND state)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module nibble_tx #(
  parameter int WORD_W    = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_word_valid,
  output logic              o_word_ready,
  output logic [3:0]        o_data,
  output logic              o_data_valid,
  input  logic              i_data_ready,
  output logic              o_last,
  output logic              o_busy
);

  localparam int N     = WORD_W / 4;
  // The counter keeps at least one bit so that WORD_W=4 still builds.
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              word_accept;
  logic              nib_xfer;
  logic              cnt_zero;
  logic [WORD_W-1:0] shreg_shifted;

  assign cnt_zero    = (cnt_q == '0);
  assign word_accept = i_word_valid && o_word_ready;
  assign nib_xfer    = o_data_valid && i_data_ready;

  // Shift direction and output tap depend on the nibble order. The shift
  // always moves the next nibble into the output position and fills the
  // vacated end with zeros.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shreg_shifted = shreg_q << 4;
      assign o_data        = shreg_q[WORD_W-1 -: 4];
    end else begin : g_lsb_first
      assign shreg_shifted = shreg_q >> 4;
      assign o_data        = shreg_q[3:0];
    end
  endgenerate

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (word_accept) begin
          shreg_d = i_word;
          cnt_d   = CNT_LAST;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (nib_xfer) begin
          if (!cnt_zero) begin
            shreg_d = shreg_shifted;
            cnt_d   = cnt_q - CNT_W'(1);
          end else if (word_accept) begin
            // The last nibble leaves on this edge and the next word loads
            // on the same edge, so no idle cycle is inserted.
            shreg_d = i_word;
            cnt_d   = CNT_LAST;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic. o_word_ready depends combinationally on i_data_ready
  // during the last nibble. The producer must not derive i_word_valid from
  // o_word_ready.
  always_comb begin
    o_data_valid = 1'b0;
    o_last       = 1'b0;
    o_busy       = 1'b0;
    o_word_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        o_word_ready = 1'b1;
      end
      ST_SEND: begin
        o_data_valid = 1'b1;
        o_busy       = 1'b1;
        o_last       = cnt_zero;
        o_word_ready = cnt_zero && i_data_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nibble_tx.sv
`timescale 1ns/1ps

module tb_nibble_tx;

  logic        clk;
  logic        rst_n;
  logic [31:0] word;
  logic        wvalid;
  logic        dready;

  // Index 0: 32-bit MSB-first, 1: 32-bit LSB-first, 2: 4-bit (N=1)
  logic [2:0]  wready;
  logic [2:0]  dvalid;
  logic [2:0]  last;
  logic [2:0]  busy;
  logic [3:0]  data [3];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the word in flight and how many of its nibbles remain
  int          rem   [3];
  logic [31:0] mword [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  nibble_tx #(.WORD_W(32), .MSB_FIRST(1'b1)) u_dut_msb (
    .i_clk(clk), .i_rst_n(rst_n), .i_word(word), .i_word_valid(wvalid),
    .o_word_ready(wready[0]), .o_data(data[0]), .o_data_valid(dvalid[0]),
    .i_data_ready(dready), .o_last(last[0]), .o_busy(busy[0])
  );

  nibble_tx #(.WORD_W(32), .MSB_FIRST(1'b0)) u_dut_lsb (
    .i_clk(clk), .i_rst_n(rst_n), .i_word(word), .i_word_valid(wvalid),
    .o_word_ready(wready[1]), .o_data(data[1]), .o_data_valid(dvalid[1]),
    .i_data_ready(dready), .o_last(last[1]), .o_busy(busy[1])
  );

  nibble_tx #(.WORD_W(4), .MSB_FIRST(1'b1)) u_dut_n1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_word(word[3:0]), .i_word_valid(wvalid),
    .o_word_ready(wready[2]), .o_data(data[2]), .o_data_valid(dvalid[2]),
    .i_data_ready(dready), .o_last(last[2]), .o_busy(busy[2])
  );

  function automatic int n_of(input int k);
    return (k == 2) ? 1 : 8;
  endfunction

  function automatic bit msb_of(input int k);
    return (k != 1);
  endfunction

  // Expected nibble: position i of the word in transmission order
  function automatic logic [3:0] exp_nib(input int k);
    int i;
    int sh;
    logic [31:0] v;
    i  = n_of(k) - rem[k];
    sh = msb_of(k) ? 4 * (n_of(k) - 1 - i) : 4 * i;
    v  = mword[k] >> sh;
    return v[3:0];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string phase);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("%s_data[%0d]", phase, k),   32'(data[k]),   32'h0);
      check_eq($sformatf("%s_dvalid[%0d]", phase, k), 32'(dvalid[k]), 32'h0);
      check_eq($sformatf("%s_last[%0d]", phase, k),   32'(last[k]),   32'h0);
      check_eq($sformatf("%s_busy[%0d]", phase, k),   32'(busy[k]),   32'h0);
      check_eq($sformatf("%s_wready[%0d]", phase, k), 32'(wready[k]), 32'h1);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model across the rising edge.
  task automatic do_cycle(input logic v, input logic [31:0] w, input logic r);
    bit exp_wr [3];
    @(negedge clk);
    wvalid = v;
    word   = w;
    dready = r;
    #1;
    for (int k = 0; k < 3; k++) begin
      exp_wr[k] = (rem[k] == 0) || (rem[k] == 1 && r);
      check_eq($sformatf("wready[%0d]", k), 32'(wready[k]), 32'(exp_wr[k]));
      check_eq($sformatf("dvalid[%0d]", k), 32'(dvalid[k]), 32'(rem[k] > 0));
      check_eq($sformatf("busy[%0d]", k),   32'(busy[k]),   32'(rem[k] > 0));
      check_eq($sformatf("last[%0d]", k),   32'(last[k]),   32'(rem[k] == 1));
      if (rem[k] > 0)
        check_eq($sformatf("data[%0d]", k), 32'(data[k]), 32'(exp_nib(k)));
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (v && exp_wr[k]) begin
        mword[k] = (k == 2) ? {28'h0, w[3:0]} : w;
        rem[k]   = n_of(k);
        if (k == 0) $display("accept word %08h", w);
      end else if (rem[k] > 0 && r) begin
        rem[k]--;
      end
    end
  endtask

  // Reset asserted between edges; outputs must clear at once.
  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst");
    for (int k = 0; k < 3; k++) rem[k] = 0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    $display("reset pulse done");
  endtask

  logic bp_pat [4];

  initial begin
    rst_n  = 1'b0;
    word   = '0;
    wvalid = 1'b0;
    dready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rem[k]   = 0;
      mword[k] = '0;
    end
    #1;
    check_reset_vals("por");
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_reset_vals("rel");

    // Single word, full rate
    do_cycle(1'b1, 32'h12345678, 1'b1);
    repeat (10) do_cycle(1'b0, 32'hFFFF_FFFF, 1'b1);

    // Back-to-back: offer A5A5A5A5 until the 32-bit unit takes it, then 0F0F0F0F
    do_cycle(1'b1, 32'hA5A5A5A5, 1'b1);
    for (int c = 0; c < 8; c++) do_cycle(1'b1, 32'h0F0F0F0F, 1'b1);
    repeat (10) do_cycle(1'b0, 32'h0, 1'b1);

    // Backpressure 1,0,0,1,...
    bp_pat[0] = 1'b1; bp_pat[1] = 1'b0; bp_pat[2] = 1'b0; bp_pat[3] = 1'b1;
    do_cycle(1'b1, 32'hDEADBEEF, 1'b1);
    for (int c = 0; c < 24; c++) do_cycle(1'b0, 32'h0, bp_pat[c % 4]);
    repeat (4) do_cycle(1'b0, 32'h0, 1'b1);

    // Reset mid-word after 3 nibbles, then a fresh word in full
    do_cycle(1'b1, 32'hCAFEF00D, 1'b1);
    repeat (3) do_cycle(1'b0, 32'h0, 1'b1);
    mid_reset();
    do_cycle(1'b1, 32'h11111111, 1'b1);
    repeat (10) do_cycle(1'b0, 32'h0, 1'b1);

    // Degenerate N=1 back-to-back 3, C
    do_cycle(1'b1, 32'h3, 1'b1);
    do_cycle(1'b1, 32'hC, 1'b1);
    repeat (9) do_cycle(1'b0, 32'h0, 1'b1);

    // Random traffic
    for (int c = 0; c < 1500; c++)
      do_cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0);
    repeat (10) do_cycle(1'b0, 32'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

endmodule
